// File: rtl/spi_bram_pkg.sv
// Shared definitions for the SPI output block RAM write side.
package spi_bram_pkg;

   localparam int DEF_AW    = 11;
   localparam int DEF_DW    = 8;
   localparam int DEF_DEPTH = 1 << DEF_AW;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } wr_state_t;

endpackage

// File: rtl/spi_bram_wr_arb_rr_arb2.sv
// Two-way round-robin picker: the requester not served last wins a tie.
module rr_arb2 (
   input  logic       clka0,
   input  logic       rstn,
   input  logic [1:0] req,
   input  logic       done,
   input  logic [1:0] done_gnt,
   output logic [1:0] gnt
);

   // Resets as if req1 was served last so req0 wins the first tie.
   logic last1;

   always_ff @(posedge clka0 or negedge rstn) begin
      if (!rstn) begin
         last1 <= 1'b1;
      end else if (done) begin
         last1 <= done_gnt[1];
      end
   end

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = last1 ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/spi_bram_wr_arb.sv
// SPI output BRAM write-port arbiter: packet-granular round-robin, write
// pointer with wrap, back-pressure against rd_ptr and a whole-packet commit pointer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no owner; picks the next packet owner when any valid is high
// ST_BUSY | grant holds the owner; bytes accepted until its last byte
module spi_bram_wr_arb
   import spi_bram_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
) (
   input  logic          clka0,
   input  logic          rstn,
   input  logic          req0_valid,
   input  logic [DW-1:0] req0_data,
   input  logic          req0_last,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic [DW-1:0] req1_data,
   input  logic          req1_last,
   output logic          req1_ready,
   input  logic [AW:0]   rd_ptr,
   output logic          wen0,
   output logic [DW-1:0] wdata0,
   output logic [AW-1:0] waddr0,
   output logic [AW:0]   commit_ptr,
   output logic [AW:0]   level,
   output logic          full,
   output logic [1:0]    grant
);

   localparam logic [AW:0] DEPTH_PTR = {1'b1, {AW{1'b0}}};

   wr_state_t     state, state_nxt;
   logic [1:0]    grant_nxt;
   logic [1:0]    pick;
   logic [AW:0]   wr_ptr, wr_ptr_nxt, lvl_nxt;
   logic          acc0, acc1, acc, acc_last;
   logic [DW-1:0] acc_data;
   logic          commit_pend;

   assign req0_ready = (state == ST_BUSY) && grant[0] && !full;
   assign req1_ready = (state == ST_BUSY) && grant[1] && !full;
   assign acc0       = req0_valid && req0_ready;
   assign acc1       = req1_valid && req1_ready;
   assign acc        = acc0 || acc1;
   assign acc_data   = acc1 ? req1_data : req0_data;
   assign acc_last   = acc && (acc1 ? req1_last : req0_last);
   assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, acc};
   // full/level look at the post-write pointer so a 2048th byte blocks the next one
   assign lvl_nxt    = wr_ptr_nxt - rd_ptr;

   rr_arb2 u_rr_arb2 (
      .clka0    (clka0),
      .rstn     (rstn),
      .req      ({req1_valid, req0_valid}),
      .done     (acc_last),
      .done_gnt (grant),
      .gnt      (pick)
   );

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      case (state)
         ST_IDLE: begin
            if (|pick) begin
               grant_nxt = pick;
               state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (acc_last) begin
               grant_nxt = 2'b00;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            grant_nxt = 2'b00;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clka0 or negedge rstn) begin
      if (!rstn) begin
         state  <= ST_IDLE;
         grant  <= 2'b00;
         wr_ptr <= '0;
      end else begin
         state  <= state_nxt;
         grant  <= grant_nxt;
         wr_ptr <= wr_ptr_nxt;
      end
   end

   always_ff @(posedge clka0 or negedge rstn) begin
      if (!rstn) begin
         wen0        <= 1'b0;
         wdata0      <= '0;
         waddr0      <= '0;
         commit_pend <= 1'b0;
         commit_ptr  <= '0;
         level       <= '0;
         full        <= 1'b0;
      end else begin
         wen0        <= acc;
         if (acc) begin
            wdata0 <= acc_data;
            waddr0 <= wr_ptr[AW-1:0];
         end
         commit_pend <= acc_last;
         if (commit_pend) begin
            commit_ptr <= wr_ptr;
         end
         level       <= lvl_nxt;
         full        <= (lvl_nxt == DEPTH_PTR);
      end
   end

endmodule
